// File: rtl/ib_ram_load_sched.sv
// rtl/ib_ram_load_sched.sv - ping-pong LUT page loader for the IB CNU function RAMs
// Optional feature: define IB_LOAD_ABORT_EN to add the load_abort input.
module ib_ram_load_sched #(
    parameter int ENTRY_ADDR      = 4,
    parameter int MULTI_FRAME_NUM = 2,
    parameter int BANK_NUM        = 2,
    parameter int LUT_PORT_SIZE   = 2
) (
    input  logic                              write_clk,
    input  logic                              rst,
`ifdef IB_LOAD_ABORT_EN
    input  logic                              load_abort,
`endif
    input  logic                              load_start,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
    input  logic                              src_valid,
    output logic                              src_ready,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic [ENTRY_ADDR-1:0]             page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
    output logic                              ib_ram_we,
    output logic                              read_addr_offset,
    output logic                              shadow_valid,
    output logic                              load_busy,
    output logic                              load_done,
    output logic                              load_reject
);
    localparam int PW       = ENTRY_ADDR - 1;
    localparam int DW       = LUT_PORT_SIZE * BANK_NUM;
    localparam int OW       = $clog2(MULTI_FRAME_NUM);
    localparam int PAGE_NUM = 1 << PW;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     page_cnt_q, page_cnt_d;
    logic [OW-1:0]     offset_q, offset_d;
    logic              shadow_valid_q, shadow_valid_d;
    logic              swap_ack_q, swap_ack_d;
    logic              load_done_q, load_done_d;
    logic              load_reject_q, load_reject_d;
    logic              we_q, we_d;
    logic [ENTRY_ADDR-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              abort;
    logic              grant;
    logic              accept;
    logic              last_page;

`ifdef IB_LOAD_ABORT_EN
    assign abort = load_abort;
`else
    assign abort = 1'b0;
`endif

    assign grant     = swap_req && shadow_valid_q && (state_q == IDLE) && !swap_ack_q;
    assign accept    = src_valid && (state_q == LOAD);
    assign last_page = (page_cnt_q == PW'(PAGE_NUM - 1));

    always_comb begin
        state_d        = state_q;
        page_cnt_d     = page_cnt_q;
        offset_d       = offset_q;
        shadow_valid_d = shadow_valid_q;
        swap_ack_d     = 1'b0;
        load_done_d    = 1'b0;
        load_reject_d  = 1'b0;
        we_d           = 1'b0;
        addr_d         = addr_q;
        data_d         = data_q;

        if (grant) begin
            offset_d       = ~offset_q;
            shadow_valid_d = 1'b0;
            swap_ack_d     = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A same-cycle swap frees the old read frame, so the load may start into it.
                if (load_start) begin
                    if (!shadow_valid_q || grant) begin
                        state_d    = LOAD;
                        page_cnt_d = '0;
                    end else begin
                        load_reject_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = {~offset_q[0], page_cnt_q};
                    data_d = src_data;
                    if (!last_page) begin
                        page_cnt_d = page_cnt_q + PW'(1);
                    end
                end
                if (abort) begin
                    state_d    = IDLE;
                    page_cnt_d = '0;
                end else if (accept && last_page) begin
                    state_d        = IDLE;
                    shadow_valid_d = 1'b1;
                    load_done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            page_cnt_q     <= '0;
            offset_q       <= '0;
            shadow_valid_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            load_done_q    <= 1'b0;
            load_reject_q  <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            page_cnt_q     <= page_cnt_d;
            offset_q       <= offset_d;
            shadow_valid_q <= shadow_valid_d;
            swap_ack_q     <= swap_ack_d;
            load_done_q    <= load_done_d;
            load_reject_q  <= load_reject_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
        end
    end

    assign src_ready        = (state_q == LOAD);
    assign load_busy        = (state_q == LOAD);
    assign swap_ack         = swap_ack_q;
    assign page_addr_ram    = addr_q;
    assign ram_write_data   = data_q;
    assign ib_ram_we        = we_q;
    assign read_addr_offset = offset_q[0];
    assign shadow_valid     = shadow_valid_q;
    assign load_done        = load_done_q;
    assign load_reject      = load_reject_q;
endmodule
